dds_top: RTL and testbench
==========================

# dds_top

Direct digital frequency synthesizer core. A 24-bit phase accumulator advances by a frequency control word (FCW) every clock. The accumulated phase is truncated to 10 bits and converted to a signed 16-bit sine sample through a quarter-wave lookup ROM. The block is the top of the DDS datapath, and its sample stream feeds the downstream PWM/DAC stage.

## Interface
- `PHASE_W`, default 24: phase accumulator width (equals FCW width).
- `ADDR_W`, default 10: truncated phase bits used for lookup; 2 quadrant bits plus 8 ROM-index bits.
- `OUT_W`, default 16: signed sample width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `FCW` input 24: unsigned phase increment, sampled every clock.
- `sine_out` output 16: signed two's-complement sine sample, registered.

## Operation
- Phase accumulator: `acc <= acc + FCW` every clock, modulo 2^24. Carry is discarded and wrap-around is silent.
- Output frequency is fclk·FCW/2^24.
  - FCW=0 holds the phase constant.
  - FCW ≥ 2^23 aliases; this is permitted and not guarded.
- Phase index: p = acc[23:14], so q = p[9:8] and i = p[7:0].
- ROM: 256 entries of 15-bit unsigned magnitude.
  - LUT[k] = round(32767·sin(2π(k+0.5)/1024)), for k = 0..255.
  - This gives LUT[0]=101 and LUT[255]=32767.
  - The ROM is constant and synthesizable (case table or constant init). It contains no runtime math.
- Quadrant mapping (half-sample offset gives exact symmetry):
  - q=0: +LUT[i]
  - q=1: +LUT[~i]
  - q=2: −LUT[i]
  - q=3: −LUT[~i]
- Output range is −32767..+32767. The values −32768 and 0 never occur after the pipeline fills.
- Sign extension: the 15-bit magnitude is zero-extended to 16 bits, then negated in two's complement for q≥2.

## Timing
- Pipeline is registered, 3 stages after the accumulator:
  - S1 registers q and i from acc.
  - S2 registers the ROM magnitude and delays q.
  - S3 registers the signed `sine_out`.
- Latency: `sine_out` after edge t equals the mapping of the `acc` value held after edge t−3.
- Throughput: one sample per clock with no stalls and no handshake.
- An FCW change affects `acc` at the next rising edge and appears at `sine_out` 3 edges later.
- Reset asserted (`reset`=0):
  - `acc`, all pipeline registers and `sine_out` clear to 0 immediately, without waiting for a clock edge.
  - They stay cleared while `reset` is held.
- Reset mid-operation: the phase is lost. After release, accumulation restarts from 0 at the first rising edge.
- First samples after release:
  - `sine_out` stays 0 for the first 2 edges (pipeline flushing reset values).
  - After the 3rd edge it shows the sample for acc=0, which is +101 when FCW=0 at that edge.

## Test plan
- Reset behaviour: drive `reset`=0 with FCW=100 -> `sine_out`=0 and acc=0, with no clock edge needed. Release with FCW=0 -> `sine_out` reads 0, 0, then +101 and holds at +101.
- Quadrant check: FCW=4194304 (2^22) from reset -> acc steps 0, 2^22, 2^23, 3·2^22. After latency, `sine_out` repeats +101, +32767, −101, −32767.
- Nyquist: FCW=8388608 (2^23) -> `sine_out` alternates +101, −101 each clock.
- Sweep, matching the system bench: FCW=100, then 10000, then 1000000, each for 5000 clocks. Required:
  - `sine_out` stays within ±32767.
  - The sign-change period at FCW=1000000 is about 16.78 clocks.
  - Each sample matches the reference model within 0 LSB.
- Wrap-around: FCW=0xFFFFFF -> acc decrements by 1 each clock, modulo 2^24. After 16384 clocks the index moves from p=0 to p=1023 and `sine_out` = −101.
- Mid-run reset: assert `reset` asynchronously between edges during FCW=10000 -> `sine_out` goes to 0 before the next edge. After release the sequence restarts identically to a cold start.

Source files
------------

// File: rtl/dds_top.sv
// -----------------------------------------------------------------------------
// dds_top
//   Direct digital frequency synthesizer datapath.
//   - A phase accumulator adds the frequency control word on every clock and
//     wraps silently.
//   - The top ADDR_W phase bits address a quarter-wave sine ROM.
//   - The ROM output is mapped to a signed sample through a 3-stage registered
//     pipeline.
//
// Ports
//   clk      : single clock, rising-edge active
//   reset    : asynchronous, active-low; clears accumulator, pipeline, output
//   FCW      : unsigned phase increment, sampled every clock
//   sine_out : signed two's-complement sine sample, registered
//
// Flow
//   There is no handshake. One sample is produced on every clock, and the
//   downstream stage simply samples sine_out each cycle.
//
// Pipeline
//   acc -> S1 (quadrant q, index i) -> S2 (ROM magnitude, q delayed)
//       -> S3 (signed sine_out)
//   After edge t, sine_out reflects the acc value held after edge t-3.
// -----------------------------------------------------------------------------
module dds_top #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 10,
  parameter int OUT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PHASE_W-1:0]        FCW,
  output logic signed [OUT_W-1:0]   sine_out
);

  localparam int IDX_W   = ADDR_W - 2;
  localparam int DEPTH   = 1 << IDX_W;
  localparam int MAG_W   = OUT_W - 1;
  localparam int MAG_MAX = (1 << MAG_W) - 1;

  // ROM contents are built at elaboration time:
  //   LUT[k] = round(MAG_MAX * sin(2*pi*(k+0.5)/(4*DEPTH)))
  // The half-sample offset makes the quarter wave exactly symmetric, so
  // mirroring the index (~i) and negating reproduce the full period without
  // a zero or a duplicated peak. The sine itself comes from a Taylor series
  // with real arithmetic, which resolves to a constant before any hardware is
  // built.
  function automatic logic [DEPTH*MAG_W-1:0] build_lut();
    logic [DEPTH*MAG_W-1:0] table_bits;
    real ang;
    real x2;
    real term;
    real s;
    int  v;
    table_bits = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ang  = 3.14159265358979323846 * (2.0 * k + 1.0) / (4.0 * DEPTH);
      x2   = ang * ang;
      term = ang;
      s    = ang;
      for (int n = 1; n < 12; n++) begin
        term = -term * x2 / ((2.0 * n) * (2.0 * n + 1.0));
        s    = s + term;
      end
      v = $rtoi(s * MAG_MAX + 0.5);
      table_bits[k*MAG_W +: MAG_W] = v[MAG_W-1:0];
    end
    return table_bits;
  endfunction

  localparam logic [DEPTH*MAG_W-1:0] LUT = build_lut();

  // Unpacked view of the ROM so the lookup is a plain array index.
  logic [MAG_W-1:0] rom [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = LUT[k*MAG_W +: MAG_W];
  end

  // Phase accumulator
  logic [PHASE_W-1:0] acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else begin
      acc <= acc + FCW;
    end
  end

  // S1: split truncated phase into quadrant and ROM index
  logic [1:0]       s1_q;
  logic [IDX_W-1:0] s1_i;
  logic [ADDR_W-1:0] phase_idx;

  assign phase_idx = acc[PHASE_W-1 -: ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s1_i <= '0;
    end else begin
      s1_q <= phase_idx[ADDR_W-1 -: 2];
      s1_i <= phase_idx[IDX_W-1:0];
    end
  end

  // S2: ROM lookup. Odd quadrants walk the quarter wave backwards.
  logic [IDX_W-1:0] rom_addr;
  logic [MAG_W-1:0] s2_mag;
  logic [1:0]       s2_q;

  assign rom_addr = s1_q[0] ? ~s1_i : s1_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_mag <= '0;
      s2_q   <= '0;
    end else begin
      s2_mag <= rom[rom_addr];
      s2_q   <= s1_q;
    end
  end

  // Fill tracker: the S1/S2 reset contents decode to a legal address, so
  // without this the ROM value for index 0 would reach the output one edge
  // early. fill[1] marks that S2 holds data derived from a real acc value.
  logic [1:0] fill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
    end else begin
      fill <= {fill[0], 1'b1};
    end
  end

  // S3: zero-extend the magnitude, negate for the lower half-period
  logic [OUT_W-1:0] mag_ext;
  logic [OUT_W-1:0] signed_val;

  assign mag_ext    = {1'b0, s2_mag};
  assign signed_val = s2_q[1] ? (~mag_ext + 1'b1) : mag_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sine_out <= '0;
    end else if (fill[1]) begin
      sine_out <= $signed(signed_val);
    end else begin
      sine_out <= '0;
    end
  end

endmodule

// File: tb/tb_dds_top.sv
// -----------------------------------------------------------------------------
// tb_dds_top
//   Directed bench for dds_top.
//   - A reference model tracks the phase and queues the expected sample for
//     every clock.
//   - A monitor pops and compares on every falling edge.
//   - Hand-computed sequences cover reset, quadrants, Nyquist, wrap-around
//     and mid-run reset.
// -----------------------------------------------------------------------------
module tb_dds_top;

  // ---------------- clock / reset / DUT ----------------
  logic               clk   = 1'b0;
  logic               reset = 1'b0;
  logic [23:0]        fcw   = 24'd0;
  logic signed [15:0] sine_out;

  dds_top #(.PHASE_W(24), .ADDR_W(10), .OUT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .FCW      (fcw),
    .sine_out (sine_out)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks      = 0;
  int errors      = 0;
  int sb_prints   = 0;

  logic [15:0] exp_q[$];
  logic [23:0] model_acc = 24'd0;
  bit          primed    = 1'b0;

  // Reference sample straight from the full-period sine at the phase
  // bin centre, rounded half away from zero.
  function automatic logic [15:0] ref_sample(input logic [23:0] a);
    int  p;
    real r;
    int  v;
    p = int'(a[23:14]);
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / 1024.0);
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else          v = -$rtoi(0.5 - r);
    return v[15:0];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (producer) ----------------
  // Item n in exp_q is the expected sine_out after the n-th edge since
  // release: two flush zeros, then the sample of the reset phase (0), then
  // one entry per edge for the phase reached at that edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_acc = 24'd0;
      exp_q.delete();
      primed = 1'b0;
    end else begin
      if (!primed) begin
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd0);
        exp_q.push_back(ref_sample(24'd0));
        primed = 1'b1;
      end
      model_acc = model_acc + fcw;
      exp_q.push_back(ref_sample(model_acc));
    end
  end

  // ---------------- monitor (consumer) ----------------
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (sine_out !== e) begin
        errors++;
        if (sb_prints < 20)
          $display("FAIL scoreboard: got %0d expected %0d", sine_out, $signed(e));
        sb_prints++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at a falling edge; asserts reset between edges and checks the
  // asynchronous clear before the next rising edge.
  task automatic do_reset(input logic [23:0] f_during);
    #2;
    reset = 1'b0;
    fcw   = f_during;
    #1;
    check("async_reset_sine", int'(sine_out), 0);
    check("async_reset_acc", int'(dut.acc), 0);
    @(negedge clk);
    @(negedge clk);
    check("held_reset_sine", int'(sine_out), 0);
  endtask

  // Entered at a falling edge; next rising edge is the first after release.
  task automatic release_with(input logic [23:0] f);
    fcw   = f;
    reset = 1'b1;
  endtask

  task automatic expect_seq(input string name, input int exp_vals[], input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(name, int'(sine_out), exp_vals[k]);
    end
  endtask

  // ---------------- stimulus ----------------
  int cold_seq[]   = '{0, 0, 101, 101, 101, 101};
  int quad_seq[]   = '{0, 0, 101, 32767, -101, -32767, 101, 32767, -101, -32767};
  int nyq_seq[]    = '{0, 0, 101, -101, 101, -101, 101, -101};
  int f10k_seq[]   = '{0, 0, 101, 101, 302, 302, 503};
  logic [23:0] sweep_fcw[3] = '{24'd100, 24'd10000, 24'd1000000};

  initial begin
    int bad_vals;
    int changes;
    logic prev_sign;

    // Cold start with FCW=0
    reset = 1'b0;
    fcw   = 24'd100;
    @(negedge clk);
    check("reset_start_sine", int'(sine_out), 0);
    check("reset_start_acc", int'(dut.acc), 0);
    release_with(24'd0);
    expect_seq("cold_start", cold_seq, 6);

    // Move the phase, then reset with FCW=100 applied
    fcw = 24'd100;
    repeat (10) @(negedge clk);
    do_reset(24'd100);

    // Quadrant walk
    release_with(24'd4194304);
    expect_seq("quadrant", quad_seq, 10);
    do_reset(24'd100);

    // Nyquist
    release_with(24'd8388608);
    expect_seq("nyquist", nyq_seq, 8);
    do_reset(24'd100);

    // Frequency sweep
    release_with(sweep_fcw[0]);
    bad_vals  = 0;
    changes   = 0;
    prev_sign = 1'b0;
    for (int seg = 0; seg < 3; seg++) begin
      fcw = sweep_fcw[seg];
      for (int n = 0; n < 5000; n++) begin
        @(negedge clk);
        if ((seg > 0 || n > 1) && (sine_out == 16'sd0 || sine_out == -16'sd32768))
          bad_vals++;
        if (seg == 2) begin
          if (n > 4 && sine_out[15] != prev_sign) changes++;
          prev_sign = sine_out[15];
        end
      end
    end
    check("sweep_range", bad_vals, 0);
    checks++;
    if (changes < 590 || changes > 602) begin
      errors++;
      $display("FAIL sign_changes: got %0d expected 590..602", changes);
    end

    // Mid-run reset during FCW=10000; restart must match a cold start
    do_reset(24'd10000);
    release_with(24'd10000);
    expect_seq("f10k_cold", f10k_seq, 7);
    repeat (30) @(negedge clk);
    do_reset(24'd10000);
    release_with(24'd10000);
    expect_seq("f10k_restart", f10k_seq, 7);
    do_reset(24'd100);

    // Wrap-around with FCW = -1
    release_with(24'hFFFFFF);
    for (int t = 1; t <= 16388; t++) begin
      @(negedge clk);
      if (t == 1)     check("wrap_acc_first", int'(dut.acc), 24'hFFFFFF);
      if (t == 4)     check("wrap_sine_first", int'(sine_out), -101);
      if (t == 16384) check("wrap_acc_16384", int'(dut.acc), 24'hFFC000);
      if (t == 16387) check("wrap_sine_p1023", int'(sine_out), -101);
      if (t == 16388) check("wrap_sine_p1022", int'(sine_out), -302);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
